// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory copy engine.
package mem_copy_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Host request/status and data-memory port of the copy engine.
interface mem_copy_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) ();

    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    // Engine side: it initiates memory accesses.
    modport master (
        input  start, src_addr, dst_addr, length, mem_read_data,
        output busy, done, mem_write, mem_address, mem_write_data
    );

    // Host plus memory side.
    modport slave (
        output start, src_addr, dst_addr, length, mem_read_data,
        input  busy, done, mem_write, mem_address, mem_write_data
    );

endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy initiator: one read cycle then one write cycle per word,
// strictly ascending addresses with wrap-around pointers.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    mem_copy_engine_if.master   bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  count_q, count_d;

    // State and pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            count_q   <= count_d;
        end
    end

    // Next-state and pointer update; start only matters while idle.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        src_ptr_d = bus.src_addr;
                        dst_ptr_d = bus.dst_addr;
                        count_d   = bus.length;
                        state_d   = RD;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                state_d = WR;
            end
            WR: begin
                src_ptr_d = src_ptr_q + ADDR_W'(1);
                dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                count_d   = count_q - LEN_W'(1);
                if (count_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so reset clears them immediately.
    always_comb begin
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
            end
            RD: begin
                bus.busy        = 1'b1;
                bus.mem_address = src_ptr_q;
            end
            WR: begin
                bus.busy           = 1'b1;
                bus.mem_write      = 1'b1;
                bus.mem_address    = dst_ptr_q;
                bus.mem_write_data = bus.mem_read_data;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule
